control_estados: RTL and testbench

CONTROL_ESTADOS -- requirements
Module: control_estados

---
 rtl/control_estados_if.sv | 25 ++
 rtl/control_estados.sv | 130 +++++++++++++
 tb/tb_control_estados.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/control_estados_if.sv
// Interface bundle for control_estados: game inputs driven by the
// environment (master) and registered status returned by the controller.
interface control_estados_if #(
  parameter int PTS_W = 16
);
  logic             tick;
  logic             keypad_pressed;
  logic [4:0]       key;
  logic             colision;
  logic [3:0]       presente;
  logic [2:0]       heroe_seleccionado;
  logic             cambio;
  logic [2:0]       vidas;
  logic [PTS_W-1:0] puntaje;

  modport master (
    output tick, keypad_pressed, key, colision,
    input  presente, heroe_seleccionado, cambio, vidas, puntaje
  );

  modport slave (
    input  tick, keypad_pressed, key, colision,
    output presente, heroe_seleccionado, cambio, vidas, puntaje
  );
endinterface

// File: rtl/control_estados.sv
// Game-flow controller: power/greeting/hero-select/play/game-over/retry
// states, with registered score, lives and state-change pulse.
module control_estados #(
  parameter int VIDAS_INI  = 3,
  parameter int HOLA_TICKS = 100,
  parameter int GP_TICKS   = 200,
  parameter int PTS_W      = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  control_estados_if.slave   bus
);
  localparam int CNT_MAX = (HOLA_TICKS > GP_TICKS) ? HOLA_TICKS : GP_TICKS;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [3:0] {
    APAGADO   = 4'd0,
    HOLA      = 4'd1,
    PERSONAJE = 4'd2,
    JUEGO     = 4'd3,
    GP        = 4'd4,
    YN        = 4'd5
  } estado_t;

  estado_t          estado_q, estado_d;
  logic [2:0]       heroe_q, heroe_d;
  logic [2:0]       vidas_q, vidas_d;
  logic [PTS_W-1:0] pts_q, pts_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             cambio_q, cambio_d;
  logic             kp_q;
  logic             arm_q;
  logic             press_s;
  logic             abort_s;

  // arm_q blanks the first cycle after reset so a key already held is not a press
  assign press_s = arm_q & bus.keypad_pressed & ~kp_q;
  assign abort_s = press_s & (bus.key == 5'd10);

  // Next-state, score, lives and tick-counter logic
  always_comb begin
    estado_d = estado_q;
    heroe_d  = heroe_q;
    vidas_d  = vidas_q;
    pts_d    = pts_q;
    cnt_d    = cnt_q;
    case (estado_q)
      APAGADO: begin
        if (abort_s) estado_d = HOLA;
        else         estado_d = APAGADO;
      end
      HOLA: begin
        if (abort_s)      estado_d = APAGADO;
        else if (press_s) estado_d = PERSONAJE;
        else if (bus.tick) begin
          if (cnt_q == CNT_W'(HOLA_TICKS - 1)) estado_d = PERSONAJE;
          else                                 cnt_d = cnt_q + CNT_W'(1);
        end else cnt_d = cnt_q;
      end
      PERSONAJE: begin
        if (abort_s) estado_d = APAGADO;
        else if (press_s && (bus.key >= 5'd1) && (bus.key <= 5'd4)) begin
          heroe_d = 3'(bus.key - 5'd1);
        end else if (press_s && (bus.key == 5'd14)) begin
          estado_d = JUEGO;
          vidas_d  = 3'(VIDAS_INI);
          pts_d    = '0;
        end else estado_d = PERSONAJE;
      end
      JUEGO: begin
        // a hit in the same cycle as a tick costs the point for that tick
        if (abort_s) estado_d = APAGADO;
        else if (bus.colision) begin
          if (vidas_q != 3'd0) vidas_d = vidas_q - 3'd1;
          else                 vidas_d = 3'd0;
          if (vidas_q <= 3'd1) estado_d = GP;
          else                 estado_d = JUEGO;
        end else if (bus.tick && (pts_q != {PTS_W{1'b1}})) begin
          pts_d = pts_q + PTS_W'(1);
        end else pts_d = pts_q;
      end
      GP: begin
        if (abort_s) estado_d = APAGADO;
        else if (bus.tick) begin
          if (cnt_q == CNT_W'(GP_TICKS - 1)) estado_d = YN;
          else                               cnt_d = cnt_q + CNT_W'(1);
        end else cnt_d = cnt_q;
      end
      YN: begin
        if (abort_s)                             estado_d = APAGADO;
        else if (press_s && (bus.key == 5'd1))   estado_d = PERSONAJE;
        else if (press_s && (bus.key == 5'd0))   estado_d = APAGADO;
        else                                     estado_d = YN;
      end
      default: estado_d = APAGADO;
    endcase
    if (estado_d != estado_q) cnt_d = '0;
    else                      cnt_d = cnt_d;
    cambio_d = (estado_d != estado_q);
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      estado_q <= APAGADO;
      heroe_q  <= 3'd0;
      vidas_q  <= 3'd0;
      pts_q    <= '0;
      cnt_q    <= '0;
      cambio_q <= 1'b0;
      kp_q     <= 1'b0;
      arm_q    <= 1'b0;
    end else begin
      estado_q <= estado_d;
      heroe_q  <= heroe_d;
      vidas_q  <= vidas_d;
      pts_q    <= pts_d;
      cnt_q    <= cnt_d;
      cambio_q <= cambio_d;
      kp_q     <= bus.keypad_pressed;
      arm_q    <= 1'b1;
    end
  end

  assign bus.presente           = estado_q;
  assign bus.heroe_seleccionado = heroe_q;
  assign bus.cambio             = cambio_q;
  assign bus.vidas              = vidas_q;
  assign bus.puntaje            = pts_q;
endmodule

// File: tb/tb_control_estados.sv
// Directed bench for control_estados: expectations are queued when stimulus
// is driven and compared on the following falling edge.
module tb_control_estados;
  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  control_estados_if #(.PTS_W(16)) bus ();
  control_estados_if #(.PTS_W(2))  bus2 ();

  control_estados #(.VIDAS_INI(3), .HOLA_TICKS(100), .GP_TICKS(200), .PTS_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave)
  );

  control_estados #(.VIDAS_INI(1), .HOLA_TICKS(3), .GP_TICKS(2), .PTS_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(bus2.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  string       tq[$];
  logic [26:0] eq[$];
  logic [3:0]  e_p;

  task automatic check_one();
    string       t;
    logic [26:0] ex;
    logic [26:0] ob;
    t  = tq.pop_front();
    ex = eq.pop_front();
    ob = {bus.presente, bus.heroe_seleccionado, bus.cambio, bus.vidas, bus.puntaje};
    total++;
    assert (ob === ex) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", t, ob, ex);
    end
  endtask

  task automatic go(input string tag, input logic r, input logic tk, input logic kp,
                    input logic [4:0] k, input logic col, input logic [3:0] np,
                    input logic [2:0] nh, input logic [2:0] nv, input logic [15:0] npts);
    logic c;
    c   = r && (np != e_p);
    e_p = np;
    @(negedge clk);
    if (tq.size() > 0) check_one();
    rst_n              = r;
    bus.tick           = tk;
    bus.keypad_pressed = kp;
    bus.key            = k;
    bus.colision       = col;
    tq.push_back(tag);
    eq.push_back({np, nh, c, nv, npts});
  endtask

  task automatic s2(input string tag, input logic tk, input logic kp, input logic [4:0] k,
                    input logic col, input logic [3:0] ep, input logic [2:0] ev,
                    input logic [1:0] epts);
    logic [8:0] ob;
    @(negedge clk);
    bus2.tick           = tk;
    bus2.keypad_pressed = kp;
    bus2.key            = k;
    bus2.colision       = col;
    @(posedge clk);
    #1;
    ob = {bus2.presente, bus2.vidas, bus2.puntaje};
    total++;
    assert (ob === {ep, ev, epts}) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, ob, {ep, ev, epts});
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    e_p   = 4'd0;
    rst_n = 1'b0;
    bus.tick = 1'b0; bus.keypad_pressed = 1'b0; bus.key = 5'd0; bus.colision = 1'b0;
    bus2.tick = 1'b0; bus2.keypad_pressed = 1'b0; bus2.key = 5'd0; bus2.colision = 1'b0;

    // reset, then a key held across reset release must not count as a press
    go("rst",      1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 4'd0, 3'd0, 3'd0, 16'd0);
    go("rst_hold", 1'b0, 1'b0, 1'b1, 5'd10, 1'b0, 4'd0, 3'd0, 3'd0, 16'd0);
    go("rel_hold", 1'b1, 1'b0, 1'b1, 5'd10, 1'b0, 4'd0, 3'd0, 3'd0, 16'd0);
    go("hold",     1'b1, 1'b0, 1'b1, 5'd10, 1'b0, 4'd0, 3'd0, 3'd0, 16'd0);
    go("idle",     1'b1, 1'b0, 1'b0, 5'd0,  1'b0, 4'd0, 3'd0, 3'd0, 16'd0);
    go("on",       1'b1, 1'b0, 1'b1, 5'd10, 1'b0, 4'd1, 3'd0, 3'd0, 16'd0);
    go("on_rel",   1'b1, 1'b0, 1'b0, 5'd0,  1'b0, 4'd1, 3'd0, 3'd0, 16'd0);
    for (int i = 0; i < 100; i++)
      go("hola_tick", 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, (i == 99) ? 4'd2 : 4'd1, 3'd0, 3'd0, 16'd0);
    go("pers_idle", 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 4'd2, 3'd0, 3'd0, 16'd0);

    // hero select, start, long hold of the start key
    go("sel3",     1'b1, 1'b0, 1'b1, 5'd3,  1'b0, 4'd2, 3'd2, 3'd0, 16'd0);
    go("sel_rel",  1'b1, 1'b0, 1'b0, 5'd0,  1'b0, 4'd2, 3'd2, 3'd0, 16'd0);
    go("start",    1'b1, 1'b0, 1'b1, 5'd14, 1'b0, 4'd3, 3'd2, 3'd3, 16'd0);
    for (int i = 0; i < 49; i++)
      go("hold14", 1'b1, 1'b0, 1'b1, 5'd14, 1'b0, 4'd3, 3'd2, 3'd3, 16'd0);
    go("st_rel",   1'b1, 1'b0, 1'b0, 5'd0,  1'b0, 4'd3, 3'd2, 3'd3, 16'd0);

    // scoring and hits, one hit sharing a cycle with a tick
    for (int i = 0; i < 5; i++)
      go("score", 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 4'd3, 3'd2, 3'd3, 16'(i + 1));
    go("hit1",     1'b1, 1'b0, 1'b0, 5'd0, 1'b1, 4'd3, 3'd2, 3'd2, 16'd5);
    go("hit_tick", 1'b1, 1'b1, 1'b0, 5'd0, 1'b1, 4'd3, 3'd2, 3'd1, 16'd5);
    go("play",     1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 4'd3, 3'd2, 3'd1, 16'd5);
    go("hit_last", 1'b1, 1'b0, 1'b0, 5'd0, 1'b1, 4'd4, 3'd2, 3'd0, 16'd5);

    // game-over screen: press and hit ignored, score frozen
    for (int i = 0; i < 200; i++)
      go("gp_tick", 1'b1, 1'b1, (i == 10), 5'd1, (i == 20),
         (i == 199) ? 4'd5 : 4'd4, 3'd2, 3'd0, 16'd5);
    go("yn_idle",  1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 4'd5, 3'd2, 3'd0, 16'd5);
    go("yn_k5",    1'b1, 1'b0, 1'b1, 5'd5, 1'b0, 4'd5, 3'd2, 3'd0, 16'd5);
    go("yn_rel",   1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 4'd5, 3'd2, 3'd0, 16'd5);
    go("yn_k1",    1'b1, 1'b0, 1'b1, 5'd1, 1'b0, 4'd2, 3'd2, 3'd0, 16'd5);
    go("k1_rel",   1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 4'd2, 3'd2, 3'd0, 16'd5);
    go("restart",  1'b1, 1'b0, 1'b1, 5'd14, 1'b0, 4'd3, 3'd2, 3'd3, 16'd0);
    go("rs_rel",   1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 4'd3, 3'd2, 3'd3, 16'd0);
    go("tick2",    1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 4'd3, 3'd2, 3'd3, 16'd1);

    // reset mid-game beats tick and hit
    go("rst_mid",  1'b0, 1'b1, 1'b0, 5'd0, 1'b1, 4'd0, 3'd0, 3'd0, 16'd0);
    go("rst_rel",  1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 4'd0, 3'd0, 3'd0, 16'd0);

    // abort key and early exit from greeting
    go("on2",       1'b1, 1'b0, 1'b1, 5'd10, 1'b0, 4'd1, 3'd0, 3'd0, 16'd0);
    go("on2_rel",   1'b1, 1'b0, 1'b0, 5'd0,  1'b0, 4'd1, 3'd0, 3'd0, 16'd0);
    go("abort_h",   1'b1, 1'b0, 1'b1, 5'd10, 1'b0, 4'd0, 3'd0, 3'd0, 16'd0);
    go("ab_rel",    1'b1, 1'b0, 1'b0, 5'd0,  1'b0, 4'd0, 3'd0, 3'd0, 16'd0);
    go("on3",       1'b1, 1'b0, 1'b1, 5'd10, 1'b0, 4'd1, 3'd0, 3'd0, 16'd0);
    go("on3_rel",   1'b1, 1'b0, 1'b0, 5'd0,  1'b0, 4'd1, 3'd0, 3'd0, 16'd0);
    go("early",     1'b1, 1'b0, 1'b1, 5'd7,  1'b0, 4'd2, 3'd0, 3'd0, 16'd0);
    go("early_rel", 1'b1, 1'b0, 1'b0, 5'd0,  1'b0, 4'd2, 3'd0, 3'd0, 16'd0);
    go("abort_p",   1'b1, 1'b0, 1'b1, 5'd10, 1'b0, 4'd0, 3'd0, 3'd0, 16'd0);
    go("abp_rel",   1'b1, 1'b0, 1'b0, 5'd0,  1'b0, 4'd0, 3'd0, 3'd0, 16'd0);
    @(negedge clk);
    check_one();

    // small instance: score saturation and single-life game over
    s2("u1_on",   1'b0, 1'b1, 5'd10, 1'b0, 4'd1, 3'd0, 2'd0);
    s2("u1_t1",   1'b1, 1'b0, 5'd0,  1'b0, 4'd1, 3'd0, 2'd0);
    s2("u1_t2",   1'b1, 1'b0, 5'd0,  1'b0, 4'd1, 3'd0, 2'd0);
    s2("u1_t3",   1'b1, 1'b0, 5'd0,  1'b0, 4'd2, 3'd0, 2'd0);
    s2("u1_go",   1'b0, 1'b1, 5'd14, 1'b0, 4'd3, 3'd1, 2'd0);
    for (int i = 0; i < 5; i++)
      s2("u1_sat", 1'b1, 1'b0, 5'd0, 1'b0, 4'd3, 3'd1, (i < 3) ? 2'(i + 1) : 2'd3);
    s2("u1_hit",  1'b0, 1'b0, 5'd0,  1'b1, 4'd4, 3'd0, 2'd3);
    s2("u1_gp1",  1'b1, 1'b0, 5'd0,  1'b1, 4'd4, 3'd0, 2'd3);
    s2("u1_gp2",  1'b1, 1'b0, 5'd0,  1'b0, 4'd5, 3'd0, 2'd3);
    s2("u1_k0",   1'b0, 1'b1, 5'd0,  1'b0, 4'd0, 3'd0, 2'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
